seg7_display_arbiter: RTL and testbench
=======================================

Name: seg7_display_arbiter

Overview:
- Shares the single 4-digit 7-segment display between NUM_REQ value producers (e.g. lift count, sensor reading, status code).
- Rotates round-robin with a fixed dwell time per source.
- A high-priority alert preempts the rotation.
- Drives the 16-bit value input of the existing digit-multiplex driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWELL_CYCLES, 50_000_000, clk cycles each source is shown before rotation (1 s at 50 MHz); minimum 2.
- BLINK_CYCLES, 12_500_000, half-period of the alert blink (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per source; bit i = source i wants display.
- req_data  input  16*NUM_REQ  source i value in bits [16*i+15:16*i], 4 hex nibbles.
- alert  input  1  level; preempts all sources while high.
- alert_data  input  16  value shown during alert.
- disp_bits  output  16  value to the display driver.
- disp_blank  output  1  1 = display driver should blank all digits.
- grant  output  NUM_REQ  one-hot currently displayed source; 0 in IDLE/ALERT.
- alert_active  output  1  high while in ALERT.
- switch_pulse  output  1  one-cycle pulse when the displayed source changes.

Behaviour:
- All outputs are registered.
- Reset values: disp_bits=16'h0000, disp_blank=0, grant=0, alert_active=0, switch_pulse=0, state=IDLE, rr pointer=0, dwell counter=0, saved grant=0.
- Reset mid-operation returns everything to these values on the same edge.

States: IDLE, SHOW, ALERT.

- IDLE:
  - disp_bits=0, grant=0.
  - If alert=1: go to ALERT.
  - Else if any req=1: round-robin pick starting at pointer. Next cycle: state=SHOW, grant=pick, pulse=1, counter=0.
  - Latency is one cycle from req to grant.
- SHOW:
  - disp_bits tracks req_data of the granted source with one-cycle latency.
  - Counter increments every cycle.
  - At counter==DWELL_CYCLES-1 with another req pending: move to the next requester in RR order after the current one; pulse=1; counter=0; pointer=new grant+1 (mod NUM_REQ).
  - At counter==DWELL_CYCLES-1 with no other req: keep grant, counter=0, no pulse.
  - Granted req drops: next cycle switch to the next pending requester (pulse=1, counter=0), or go to IDLE if none pending (pulse=0, disp_bits=0).
- ALERT:
  - Entered from any state on alert=1; alert has priority over dwell expiry and req changes in the same cycle.
  - On entry: saved_grant=grant, grant=0, alert_active=1, disp_bits=alert_data (tracked each cycle), pulse=1 on entry.
  - On alert=0:
    - If saved source still requests: return to it, counter=0, pulse=1.
    - Else if another req is pending: RR pick, pulse=1.
    - Else: IDLE.
- Round-robin:
  - Search order pointer, pointer+1, ..., wrap at NUM_REQ-1 to 0.
  - Single requester: that source is kept indefinitely.
- Counter width: $clog2(DWELL_CYCLES). Must never wrap past DWELL_CYCLES-1.
- A req that rises and falls between dwell expiries while not granted is not remembered.

Optional Feature:
- Macro SEG7_ARB_ALERT_BLINK_EN.
- Defined:
  - In ALERT, a blink counter toggles disp_blank every BLINK_CYCLES, starting with disp_blank=0 on entry.
  - disp_blank is forced to 0 on exit.
  - Blink counter is reset on each ALERT entry.
- Undefined: disp_blank is constant 0; no blink counter is synthesized.

Decomposition:
- Package seg7_disp_pkg holds:
  - state enum (IDLE, SHOW, ALERT)
  - DISP_W=16
  - DISP_IDLE_VALUE=16'h0000
- Sub-module seg7_rr_pick: combinational round-robin picker. Inputs: req vector, pointer, exclude-current flag. Outputs: one-hot pick, any_valid.

Test Plan:
1. Reset then req=4'b0000, 20 cycles -> disp_bits=0, grant=0, switch_pulse never high.
2. DWELL_CYCLES=8, req=4'b0101, data0=16'h1234, data2=16'hABCD:
   - grant=0001 one cycle after req.
   - disp_bits=1234 for 8 cycles, then grant=0100, disp_bits=ABCD, one pulse.
   - Alternates thereafter.
3. Only req[1]=1 for 40 cycles -> grant stays 0010, no pulse after the first.
4. While showing source 0, drop req[0] with req[3]=1 -> next cycle grant=1000, pulse=1, counter restarts.
5. Alert=1 with alert_data=16'hEEEE mid-dwell of source 2:
   - Next cycle grant=0, alert_active=1, disp_bits=EEEE.
   - After alert drops, grant=0100 with a full fresh dwell.
6. Assert rst during ALERT -> all outputs at reset values next edge. With SEG7_ARB_ALERT_BLINK_EN and BLINK_CYCLES=4, disp_blank toggles every 4 cycles in ALERT before the reset.

Source files
------------

// File: rtl/seg7_disp_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package seg7_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALERT = 2'd2
  } state_t;

  localparam int DISP_W = 16;
  localparam logic [DISP_W-1:0] DISP_IDLE_VALUE = 16'h0000;

  // Successor of idx in round-robin order over n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// optionally skipping the slot just before ptr (the one currently shown).
module seg7_rr_pick
  import seg7_disp_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       excl_cur,
  output logic [NUM_REQ-1:0]         pick,
  output logic                       any_valid
);

  always_comb begin
    int idx;
    int excl_idx;
    pick      = '0;
    any_valid = 1'b0;
    idx       = int'(ptr);
    excl_idx  = (idx == 0) ? NUM_REQ - 1 : idx - 1;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!any_valid && req[idx] && !(excl_cur && idx == excl_idx)) begin
        pick[idx] = 1'b1;
        any_valid = 1'b1;
      end
      idx = rr_next(idx, NUM_REQ);
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin sharing of one 4-digit display among NUM_REQ sources with alert preemption.
// Optional alert blinking is built when SEG7_ARB_ALERT_BLINK_EN is defined.
//
// state | meaning
// IDLE  | nothing requested, display shows DISP_IDLE_VALUE
// SHOW  | one source granted, dwell counter running
// ALERT | alert_data shown, granted source saved for return
module seg7_display_arbiter
  import seg7_disp_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [DISP_W*NUM_REQ-1:0]  req_data,
  input  logic                       alert,
  input  logic [DISP_W-1:0]          alert_data,
  output logic [DISP_W-1:0]          disp_bits,
  output logic                       disp_blank,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       alert_active,
  output logic                       switch_pulse
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DWELL_CYCLES);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DWELL_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_bad_params
    $error("seg7_display_arbiter: parameter out of range");
  end

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  saved_q, saved_d;
  logic [NUM_REQ-1:0]  grant_d;
  logic [DISP_W-1:0]   disp_d;
  logic                pulse_d, alert_act_d;
  logic [NUM_REQ-1:0]  pick;
  logic                any_valid;
  logic                cur_req, saved_req, dwell_done;

  assign cur_req    = |(req & grant);
  assign saved_req  = |(req & saved_q);
  assign dwell_done = (cnt_q == CW'(DWELL_CYCLES - 1));

  // Only in SHOW is the slot before ptr the live grant that rotation must skip.
  seg7_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .excl_cur  (state_q == SHOW),
    .pick      (pick),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      saved_q      <= '0;
      grant        <= '0;
      disp_bits    <= DISP_IDLE_VALUE;
      alert_active <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      saved_q      <= saved_d;
      grant        <= grant_d;
      disp_bits    <= disp_d;
      alert_active <= alert_act_d;
      switch_pulse <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (alert) begin
      state_d = ALERT;
    end else begin
      case (state_q)
        IDLE:    if (any_valid) state_d = SHOW;
        SHOW:    if (!cur_req && !any_valid) state_d = IDLE;
        ALERT:   state_d = (saved_req || any_valid) ? SHOW : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    int gidx;
    grant_d     = grant;
    saved_d     = saved_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pulse_d     = 1'b0;
    alert_act_d = 1'b0;
    disp_d      = DISP_IDLE_VALUE;
    gidx        = 0;
    if (state_d == ALERT) begin
      grant_d     = '0;
      cnt_d       = '0;
      alert_act_d = 1'b1;
      disp_d      = alert_data;
      if (state_q != ALERT) begin
        saved_d = grant;
        pulse_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_d = pick;
            pulse_d = 1'b1;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          // A dropped grant switches immediately; otherwise rotate only at dwell end.
          if (!cur_req || dwell_done) begin
            cnt_d = '0;
            if (any_valid) begin
              grant_d = pick;
              pulse_d = 1'b1;
            end else if (!cur_req) begin
              grant_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ALERT: begin
          cnt_d   = '0;
          saved_d = '0;
          if (saved_req) begin
            grant_d = saved_q;
            pulse_d = 1'b1;
          end else if (any_valid) begin
            grant_d = pick;
            pulse_d = 1'b1;
          end else begin
            grant_d = '0;
          end
        end
        default: grant_d = '0;
      endcase
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_d[i]) gidx = i;
      end
      if (state_d == SHOW) disp_d = req_data[DISP_W*gidx +: DISP_W];
      if (pulse_d) ptr_d = PW'(rr_next(gidx, NUM_REQ));
    end
  end

`ifdef SEG7_ARB_ALERT_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          blank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (state_d == ALERT && state_q == ALERT) begin
      if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt_q <= '0;
        blank_q     <= ~blank_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end
  end

  assign disp_blank = blank_q;
`else
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter (NUM_REQ=4, DWELL_CYCLES=8, BLINK_CYCLES=4).
module tb_seg7_display_arbiter;

`ifdef SEG7_ARB_ALERT_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic        alert;
  logic [15:0] alert_data;
  logic [15:0] disp_bits;
  logic        disp_blank;
  logic [3:0]  grant;
  logic        alert_active;
  logic        switch_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [3:0]  grant;
    logic [15:0] disp;
    logic        pulse;
    logic        alert_act;
    logic        blank;
  } exp_t;

  exp_t sb[$];

  seg7_display_arbiter #(
    .NUM_REQ      (4),
    .DWELL_CYCLES (8),
    .BLINK_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .alert        (alert),
    .alert_data   (alert_data),
    .disp_bits    (disp_bits),
    .disp_blank   (disp_blank),
    .grant        (grant),
    .alert_active (alert_active),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_blank(input int j);
    return BLINK_EN && (((j / 4) % 2) == 1);
  endfunction

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (grant === e.grant) else begin
      errors++;
      $error("FAIL %s grant: got %b expected %b", e.tag, grant, e.grant);
    end
    checks++;
    assert (disp_bits === e.disp) else begin
      errors++;
      $error("FAIL %s disp_bits: got %h expected %h", e.tag, disp_bits, e.disp);
    end
    checks++;
    assert (switch_pulse === e.pulse) else begin
      errors++;
      $error("FAIL %s switch_pulse: got %b expected %b", e.tag, switch_pulse, e.pulse);
    end
    checks++;
    assert (alert_active === e.alert_act) else begin
      errors++;
      $error("FAIL %s alert_active: got %b expected %b", e.tag, alert_active, e.alert_act);
    end
    checks++;
    assert (disp_blank === e.blank) else begin
      errors++;
      $error("FAIL %s disp_blank: got %b expected %b", e.tag, disp_blank, e.blank);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [15:0] d,
                      input logic p, input logic a, input logic b);
    exp_t e;
    e.tag = tag; e.grant = g; e.disp = d; e.pulse = p; e.alert_act = a; e.blank = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic show(input string tag, input logic [3:0] g, input logic [15:0] d, input logic p);
    step(tag, g, d, p, 1'b0, 1'b0);
  endtask

  task automatic alrt(input string tag, input logic [15:0] d, input logic p, input int j);
    step(tag, 4'b0000, d, p, 1'b1, exp_blank(j));
  endtask

  initial begin
    rst        = 1'b1;
    req        = 4'b0000;
    req_data   = {16'h7777, 16'hABCD, 16'h5555, 16'h1234};
    alert      = 1'b0;
    alert_data = 16'h0000;

    show("reset", 4'b0000, 16'h0000, 1'b0);
    show("reset", 4'b0000, 16'h0000, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) show("idle", 4'b0000, 16'h0000, 1'b0);

    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      logic [3:0]  g;
      logic [15:0] d;
      g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      d = (k % 2 == 0) ? 16'h1234 : 16'hABCD;
      show("rr_switch", g, d, 1'b1);
      for (int i = 0; i < 7; i++) show("rr_dwell", g, d, 1'b0);
    end

    req = 4'b0010;
    show("single_take", 4'b0010, 16'h5555, 1'b1);
    for (int i = 0; i < 40; i++) show("single_hold", 4'b0010, 16'h5555, 1'b0);

    req = 4'b0001;
    show("drop_to0", 4'b0001, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) show("hold0", 4'b0001, 16'h1234, 1'b0);
    req = 4'b1000;
    show("drop_switch", 4'b1000, 16'h7777, 1'b1);
    req = 4'b1010;
    for (int i = 0; i < 7; i++) show("restart_dwell", 4'b1000, 16'h7777, 1'b0);
    show("dwell_after_drop", 4'b0010, 16'h5555, 1'b1);

    req = 4'b0100;
    show("take2", 4'b0100, 16'hABCD, 1'b1);
    for (int i = 0; i < 3; i++) show("hold2", 4'b0100, 16'hABCD, 1'b0);
    alert = 1'b1;
    alert_data = 16'hEEEE;
    for (int j = 0; j < 10; j++) begin
      if (j == 5) alert_data = 16'hE0E0;
      alrt("alert", (j < 5) ? 16'hEEEE : 16'hE0E0, j == 0, j);
    end
    alert = 1'b0;
    req = 4'b0101;
    show("alert_return", 4'b0100, 16'hABCD, 1'b1);
    for (int i = 0; i < 7; i++) show("fresh_dwell", 4'b0100, 16'hABCD, 1'b0);
    show("post_alert_rr", 4'b0001, 16'h1234, 1'b1);

    alert = 1'b1;
    alert_data = 16'hEEEE;
    alrt("alert2_entry", 16'hEEEE, 1'b1, 0);
    req = 4'b0100;
    alrt("alert2", 16'hEEEE, 1'b0, 1);
    alrt("alert2", 16'hEEEE, 1'b0, 2);
    alert = 1'b0;
    show("alert_rr_pick", 4'b0100, 16'hABCD, 1'b1);

    alert = 1'b1;
    alrt("alert3_entry", 16'hEEEE, 1'b1, 0);
    req = 4'b0000;
    alrt("alert3", 16'hEEEE, 1'b0, 1);
    alert = 1'b0;
    show("alert_to_idle", 4'b0000, 16'h0000, 1'b0);

    req = 4'b0100;
    show("idle_pick", 4'b0100, 16'hABCD, 1'b1);
    alert = 1'b1;
    for (int j = 0; j < 10; j++) alrt("alert_blink", 16'hEEEE, j == 0, j);
    rst = 1'b1;
    step("reset_in_alert", 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    alert = 1'b0;
    req = 4'b0000;
    show("after_reset", 4'b0000, 16'h0000, 1'b0);
    req = 4'b1111;
    show("ptr_reset", 4'b0001, 16'h1234, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
